// File: rtl/prog_mem_loader_pkg.sv
// Shared types and width helpers for the program-memory loader.
// CHECKSUM_EN adds the CHK state that verifies a trailing mod-256 sum byte.
package prog_mem_loader_pkg;

  localparam int BYTE_WIDTH      = 8;
  localparam int DEF_INSTR_WIDTH = 12;

  function automatic int bytes_per_word(input int instr_width);
    return (instr_width + BYTE_WIDTH - 1) / BYTE_WIDTH;
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(DEF_INSTR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_WRITE,
`ifdef CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } ldr_state_t;

endpackage

// File: rtl/prog_mem_loader_byte_assembler.sv
// Packs accepted stream bytes (low byte first) into one instruction word; word_rdy_o flags the last byte.
// One byte per cycle, no internal stall: the caller only presents bytes it has already accepted.
module byte_assembler
  import prog_mem_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr_i,
  input  logic                   byte_vld_i,
  input  logic [BYTE_WIDTH-1:0]  byte_dat_i,
  output logic [INSTR_WIDTH-1:0] word_o,
  output logic                   word_rdy_o
);

  localparam int BPW   = bytes_per_word(INSTR_WIDTH);
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BPW - 1);

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [INSTR_WIDTH-1:0] word_q, word_d;

  // Bits of the top byte that fall above INSTR_WIDTH have no storage and are dropped.
  for (genvar i = 0; i < INSTR_WIDTH; i++) begin : g_bit
    assign word_d[i] = clr_i ? 1'b0 :
                       (byte_vld_i && cnt_q == CNT_W'(i / BYTE_WIDTH)) ? byte_dat_i[i % BYTE_WIDTH] :
                       word_q[i];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (byte_vld_i) begin
      cnt_d = (cnt_q == LAST_BYTE) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_o     = word_q;
  assign word_rdy_o = byte_vld_i && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/prog_mem_loader.sv
// Loads the whole program memory from a byte stream while holding the CPU; 2 bytes + 1 write cycle per word.
// Owns the memory address port; CHECKSUM_EN adds a trailing checksum byte and the sticky ld_err flag.
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld_start,
  input  logic                   ld_valid,
  input  logic [7:0]             ld_data,
  output logic                   ld_ready,
  input  logic [ADDR_WIDTH-1:0]  cpu_pc,
  output logic                   cpu_hold,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_we,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   ld_err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  ldr_state_t             state_q;
  logic [ADDR_WIDTH-1:0]  wr_ptr_q;
  logic                   ld_ready_q, mem_we_q, done_q;
  logic                   start, accept, word_rdy;
  logic [INSTR_WIDTH-1:0] word;

  assign start  = (state_q == S_IDLE) && ld_start;
  assign accept = ld_valid && ld_ready_q;

  byte_assembler #(.INSTR_WIDTH(INSTR_WIDTH)) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (start),
    .byte_vld_i (accept && (state_q == S_RX)),
    .byte_dat_i (ld_data),
    .word_o     (word),
    .word_rdy_o (word_rdy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      ld_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ld_start) begin
            state_q    <= S_RX;
            wr_ptr_q   <= '0;
            ld_ready_q <= 1'b1;
          end
        end
        S_RX: begin
          if (word_rdy) begin
            state_q    <= S_WRITE;
            ld_ready_q <= 1'b0;
            mem_we_q   <= 1'b1;
          end
        end
        S_WRITE: begin
          mem_we_q <= 1'b0;
          if (wr_ptr_q == LAST_ADDR) begin
`ifdef CHECKSUM_EN
            state_q    <= S_CHK;
            ld_ready_q <= 1'b1;
`else
            state_q <= S_DONE;
            done_q  <= 1'b1;
`endif
          end else begin
            wr_ptr_q   <= wr_ptr_q + 1'b1;
            state_q    <= S_RX;
            ld_ready_q <= 1'b1;
          end
        end
`ifdef CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            state_q    <= S_DONE;
            ld_ready_q <= 1'b0;
            done_q     <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          ld_ready_q <= 1'b0;
          mem_we_q   <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

`ifdef CHECKSUM_EN
  logic [7:0] sum_q;
  logic       ld_err_q;

  // Only data bytes enter the sum; the checksum byte itself is compared, not added.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q    <= '0;
      ld_err_q <= 1'b0;
    end else if (start) begin
      sum_q    <= '0;
      ld_err_q <= 1'b0;
    end else if (accept && state_q == S_RX) begin
      sum_q <= sum_q + ld_data;
    end else if (accept && state_q == S_CHK) begin
      ld_err_q <= (ld_data != sum_q);
    end
  end

  assign ld_err = ld_err_q;
`else
  assign ld_err = 1'b0;
`endif

  assign busy      = (state_q != S_IDLE);
  assign cpu_hold  = busy;
  assign mem_addr  = busy ? wr_ptr_q : cpu_pc;
  assign mem_we    = mem_we_q;
  assign mem_wdata = word;
  assign ld_ready  = ld_ready_q;
  assign done      = done_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader at ADDR_WIDTH=4, INSTR_WIDTH=12 (checksum steps follow CHECKSUM_EN).
module tb_prog_mem_loader;

  logic        clk = 1'b0;
  logic        reset, ld_start, ld_valid, ld_ready;
  logic [7:0]  ld_data;
  logic [3:0]  cpu_pc, mem_addr;
  logic        cpu_hold, mem_we, busy, done, ld_err;
  logic [11:0] mem_wdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [11:0] mem [16];
  logic [3:0]  wlog_a [256];
  logic [11:0] wlog_d [256];
  int          wr_n = 0;
  bit          rdy_in_write = 1'b0;

`ifdef CHECKSUM_EN
  localparam int EXP_LAT = 49;
  localparam int NBYTES  = 33;
  localparam logic EXP_ERR = 1'b1;
`else
  localparam int EXP_LAT = 48;
  localparam int NBYTES  = 32;
  localparam logic EXP_ERR = 1'b0;
`endif

  prog_mem_loader #(.ADDR_WIDTH(4), .INSTR_WIDTH(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .cpu_pc    (cpu_pc),
    .cpu_hold  (cpu_hold),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .ld_err    (ld_err)
  );

  always #5 clk = ~clk;

  // Program memory model plus a log of every write the DUT issues.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      if (wr_n < 256) begin
        wlog_a[wr_n] <= mem_addr;
        wlog_d[wr_n] <= mem_wdata;
      end
      wr_n <= wr_n + 1;
      if (ld_ready) rdy_in_write <= 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // pattern 0: word k = bytes {k, 0x0F&~k}; pattern 1: bytes {0xA0|k, 0x05}
  function automatic logic [7:0] bval(input int pat, input int idx);
    logic [7:0] k;
    k = 8'(idx / 2);
    if (pat == 0) return (idx % 2 == 0) ? k : (8'h0F & ~k);
    return (idx % 2 == 0) ? (8'hA0 | k) : 8'h05;
  endfunction

  function automatic logic [11:0] wexp(input int pat, input int k);
    logic [7:0] kk;
    kk = 8'(k);
    if (pat == 0) return {~kk[3:0], kk};
    return {4'h5, 8'hA0 | kk};
  endfunction

  task automatic load(input int pat, input int thr, input int stop_wr, input int poke,
                      input int sum_off, output int lat);
    int idx, n, base, rx;
    logic [7:0] sum;
    bit acc, hold_ok;
    sum = 8'h00; hold_ok = 1'b1; lat = -1; base = wr_n;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    rx = cyc;
    idx = 0; n = 0;
    while (idx < NBYTES && n < 300 && (wr_n - base) < stop_wr) begin
      ld_data  = (idx < 32) ? bval(pat, idx) : sum + 8'(sum_off);
      ld_valid = (thr == 0) || (n % 2 == 0);
      ld_start = (idx == 2 * poke);
      acc = ld_valid && ld_ready;
      if (acc && idx < 32) sum = sum + ld_data;
      if (cpu_hold !== 1'b1) hold_ok = 1'b0;
      step();
      if (acc) idx++;
      n++;
    end
    ld_valid = 1'b0; ld_start = 1'b0; ld_data = 8'h00;
    chk("hold_during_load", 32'(hold_ok), 32'd1);
    if ((wr_n - base) >= stop_wr) return;
    for (int w = 0; w < 8 && done !== 1'b1; w++) step();
    chk("done_pulse", 32'(done), 32'd1);
    lat = cyc - rx;
  endtask

  task automatic chk_words(input string tag, input int base, input int pat);
    chk({tag, "_count"}, 32'(wr_n - base), 32'd16);
    for (int k = 0; k < 16; k++) begin
      chk({tag, "_addr"}, 32'(wlog_a[base + k]), 32'(k));
      chk({tag, "_data"}, 32'(wlog_d[base + k]), 32'(wexp(pat, k)));
    end
  endtask

  initial begin
    int lat, b;
    reset = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; cpu_pc = 4'd9;
    #1;
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_mem_we",   32'(mem_we),   32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_ld_err",   32'(ld_err),   32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd9);
    step(); step();
    reset = 1'b0;

    // idle passthrough with a valid byte stream that must be ignored
    ld_valid = 1'b1; ld_data = 8'h5A;
    for (int p = 0; p < 16; p++) begin
      cpu_pc = 4'(p);
      step();
      chk("idle_mem_addr", 32'(mem_addr), 32'(p));
      chk("idle_cpu_hold", 32'(cpu_hold), 32'd0);
      chk("idle_mem_we",   32'(mem_we),   32'd0);
      chk("idle_ld_ready", 32'(ld_ready), 32'd0);
    end
    ld_valid = 1'b0; cpu_pc = 4'd9;

    // full back-to-back load
    b = wr_n;
    load(0, 0, 99, -1, 0, lat);
    chk("full_latency", 32'(lat), 32'(EXP_LAT));
    chk_words("full", b, 0);
    chk("full_word3_lit",  32'(wlog_d[b + 3]),  32'h0C03);
    chk("full_word15_lit", 32'(wlog_d[b + 15]), 32'h000F);
    step();
    chk("post_done_done", 32'(done),     32'd0);
    chk("post_done_busy", 32'(busy),     32'd0);
    chk("post_done_hold", 32'(cpu_hold), 32'd0);
    chk("post_done_err",  32'(ld_err),   32'd0);
    chk("post_done_addr", 32'(mem_addr), 32'd9);

    // throttled source
    b = wr_n;
    load(0, 1, 99, -1, 0, lat);
    chk_words("thr", b, 0);
    step();

    // redundant ld_start during word 3
    b = wr_n;
    load(0, 0, 99, 3, 0, lat);
    chk("poke_latency", 32'(lat), 32'(EXP_LAT));
    chk_words("poke", b, 0);
    step();

    // reset after word 5 has been written
    b = wr_n;
    load(1, 0, 6, -1, 0, lat);
    chk("rst_mid_writes", 32'(wr_n - b), 32'd6);
    chk("rst_mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_busy",     32'(busy),     32'd0);
    chk("rst_mid_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_mid_hold",     32'(cpu_hold), 32'd0);
    chk("rst_mid_we",       32'(mem_we),   32'd0);
    chk("rst_mid_done",     32'(done),     32'd0);
    chk("rst_mid_addr",     32'(mem_addr), 32'd9);
    step();
    reset = 1'b0;
    chk("rst_mid_mem0", 32'(mem[0]), 32'h05A0);
    chk("rst_mid_mem5", 32'(mem[5]), 32'h05A5);
    chk("rst_mid_mem6", 32'(mem[6]), 32'h0906);
    chk("rst_mid_mem15", 32'(mem[15]), 32'h000F);

    // reload after reset starts at address 0
    b = wr_n;
    load(0, 0, 99, -1, 0, lat);
    chk_words("reload", b, 0);
    chk("reload_mem0", 32'(mem[0]), 32'h0F00);
    step();
    chk("reload_err", 32'(ld_err), 32'd0);

    // wrong checksum byte (sum+1): sticky error until next start
    load(0, 0, 99, -1, 1, lat);
    step();
    chk("err_after_done", 32'(ld_err), 32'(EXP_ERR));
    step();
    chk("err_sticky_idle", 32'(ld_err), 32'(EXP_ERR));
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    chk("err_cleared", 32'(ld_err), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);

    chk("ready_low_in_write", 32'(rdy_in_write), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
